flash_read_arbiter: RTL

- Shares the single-byte-stream SPI flash reader between two clients, e.g. the video fetcher (client 0) and the asset/config loader (client 1).
- Each client posts a burst request (start address, byte length). The block splits long bursts into chunks of at most CHUNK bytes and arbitrates round-robin per chunk.
- It drives the reader's rd/addr/halt_rd and routes returned bytes, tagged by client.
- The reader has no backpressure, so clients must accept rd_valid unconditionally.

---
 rtl/flash_read_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter that shares one single-stream SPI flash reader between
// two burst clients. Bursts are cut into chunks of at most CHUNK bytes so that
// a long transfer from one client cannot starve the other, and every returned
// byte is tagged with the client that owns it.
module flash_read_arbiter #(
  parameter int CHUNK = 256,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_req,
  input  logic [23:0]      c0_addr,
  input  logic [LEN_W-1:0] c0_len,
  output logic             c0_ack,
  output logic             c0_done,
  input  logic             c1_req,
  input  logic [23:0]      c1_addr,
  input  logic [LEN_W-1:0] c1_len,
  output logic             c1_ack,
  output logic             c1_done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_client,
  output logic             rd_last,
  output logic [23:0]      flash_addr,
  output logic             flash_rd,
  output logic             flash_halt_rd,
  input  logic [7:0]       flash_q,
  input  logic             flash_read_ready,
  input  logic             flash_busy,
  output logic             busy
);

  localparam logic [LEN_W-1:0] CHUNK_L = LEN_W'(CHUNK);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic [1:0] {RECOVER, IDLE, STREAM, DRAIN} state_t;
  state_t state, next_state;

  logic [1:0]       req;
  logic [23:0]      req_addr [2];
  logic [LEN_W-1:0] req_len  [2];

  logic [1:0]       pending;
  logic [23:0]      ctx_addr [2];
  logic [LEN_W-1:0] ctx_rem  [2];
  logic [1:0]       ack_q;
  logic [1:0]       done_q;

  logic             last_grant;
  logic [LEN_W-1:0] chunk_len;
  logic [LEN_W-1:0] rcvd;
  logic             halt_sent;

  logic [1:0]       eligible;
  logic             start;
  logic             grant;
  logic [LEN_W-1:0] start_len;
  logic             halt_now;
  logic             chunk_end;
  logic             req_end;

  assign req         = {c1_req, c0_req};
  assign req_addr[0] = c0_addr;
  assign req_addr[1] = c1_addr;
  assign req_len[0]  = c0_len;
  assign req_len[1]  = c1_len;

  assign c0_ack  = ack_q[0];
  assign c1_ack  = ack_q[1];
  assign c0_done = done_q[0];
  assign c1_done = done_q[1];

  // State register; reset lands in RECOVER because the reader itself is never reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RECOVER;
    else       state <= next_state;
  end

  // Next-state logic plus the per-cycle control strobes that the registers below consume.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    grant      = last_grant;
    start_len  = '0;
    halt_now   = 1'b0;
    chunk_end  = 1'b0;
    req_end    = 1'b0;
    eligible   = {pending[1] && (ctx_rem[1] != '0), pending[0] && (ctx_rem[0] != '0)};
    case (state)
      RECOVER: begin
        halt_now = flash_busy && !halt_sent;
        if (!flash_busy) next_state = IDLE;
      end
      IDLE: begin
        if (!flash_busy && (eligible != 2'b00)) begin
          start      = 1'b1;
          grant      = (eligible == 2'b11) ? ~last_grant : eligible[1];
          next_state = STREAM;
        end
      end
      STREAM: begin
        halt_now = !halt_sent && ((chunk_len - rcvd) == ONE);
        if (flash_read_ready && ((rcvd + ONE) == chunk_len)) begin
          chunk_end  = 1'b1;
          req_end    = (ctx_rem[last_grant] == chunk_len);
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!flash_busy) next_state = IDLE;
      end
      default: next_state = RECOVER;
    endcase
    start_len = (ctx_rem[grant] < CHUNK_L) ? ctx_rem[grant] : CHUNK_L;
  end

  // Client contexts: latch new requests, retire zero-length ones, advance after each chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        ctx_addr[i] <= '0;
        ctx_rem[i]  <= '0;
      end
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (!pending[i] && req[i]) begin
          pending[i]  <= 1'b1;
          ctx_addr[i] <= req_addr[i];
          ctx_rem[i]  <= req_len[i];
          ack_q[i]    <= 1'b1;
        end else if (pending[i] && (ctx_rem[i] == '0)) begin
          pending[i] <= 1'b0;
          done_q[i]  <= 1'b1;
        end else if (chunk_end && (last_grant == i[0])) begin
          ctx_addr[i] <= ctx_addr[i] + 24'(chunk_len);
          ctx_rem[i]  <= ctx_rem[i] - chunk_len;
          if (req_end) begin
            pending[i] <= 1'b0;
            done_q[i]  <= 1'b1;
          end
        end
      end
    end
  end

  // Reader strobes, chunk bookkeeping and the tagged byte stream back to the clients.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_rd      <= 1'b0;
      flash_halt_rd <= 1'b0;
      flash_addr    <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_client     <= 1'b0;
      rd_last       <= 1'b0;
      busy          <= 1'b0;
      last_grant    <= 1'b1;
      chunk_len     <= '0;
      rcvd          <= '0;
      halt_sent     <= 1'b0;
    end else begin
      flash_rd      <= start;
      flash_halt_rd <= halt_now;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      busy          <= (state != IDLE) || (pending != 2'b00);
      if (start) begin
        last_grant <= grant;
        flash_addr <= ctx_addr[grant];
        chunk_len  <= start_len;
        rcvd       <= '0;
        halt_sent  <= 1'b0;
      end else if (halt_now) begin
        halt_sent <= 1'b1;
      end
      if ((state == STREAM) && flash_read_ready) begin
        rd_valid  <= 1'b1;
        rd_data   <= flash_q;
        rd_client <= last_grant;
        rd_last   <= req_end;
        rcvd      <= rcvd + ONE;
      end
    end
  end

endmodule
